// File: rtl/sim_run_ctrl.sv
// sim_run_ctrl: core reset sequencing, run counters, halt/self-loop/watchdog completion monitor.
// Optional PC trace buffer enabled by defining SIM_RUN_CTRL_TRACE_EN.
module sim_run_ctrl #(
  parameter int PC_WIDTH    = 32,
  parameter int CNT_WIDTH   = 32,
  parameter int RST_CYCLES  = 2,
  parameter int MAX_CYCLES  = 1000,
  parameter int STALL_LIMIT = 4,
  parameter int TRACE_DEPTH = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [PC_WIDTH-1:0]            pc_in,
  input  logic                           instr_valid,
  input  logic                           halt_req,
  output logic                           core_rst,
  output logic                           running,
  output logic                           done,
  output logic                           timeout,
  output logic [CNT_WIDTH-1:0]           cycle_cnt,
  output logic [CNT_WIDTH-1:0]           instr_cnt,
  output logic [PC_WIDTH-1:0]            final_pc,
  input  logic [$clog2(TRACE_DEPTH)-1:0] trace_addr,
  output logic [PC_WIDTH-1:0]            trace_data
);
  localparam int AW = $clog2(TRACE_DEPTH);
  localparam int HW = RST_CYCLES > 1 ? $clog2(RST_CYCLES) : 1;
  localparam int SW = STALL_LIMIT > 0 ? $clog2(STALL_LIMIT + 1) : 1;
  typedef enum logic [2:0] {IDLE, HOLD, RUN, DONE, TIMEOUT} state_t;
  state_t              state;
  logic [HW-1:0]       hold_cnt;
  logic [SW-1:0]       stall_cnt;
  logic [PC_WIDTH-1:0] prev_pc;
  logic                prev_v;
  logic                go, repeat_pc, stall_hit, wdog_hit, end_done;
  always_comb begin
    go        = start && (state == IDLE || state == DONE || state == TIMEOUT);
    repeat_pc = instr_valid && prev_v && pc_in == prev_pc;
    stall_hit = STALL_LIMIT != 0 && repeat_pc && stall_cnt == SW'(STALL_LIMIT - 1);
    wdog_hit  = MAX_CYCLES != 0 && cycle_cnt == CNT_WIDTH'(MAX_CYCLES - 1);
    end_done  = halt_req || stall_hit;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      stall_cnt <= '0;
      prev_pc   <= '0;
      prev_v    <= 1'b0;
      core_rst  <= 1'b1;
      running   <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      cycle_cnt <= '0;
      instr_cnt <= '0;
      final_pc  <= '0;
    end else if (go) begin
      state     <= HOLD;
      hold_cnt  <= '0;
      stall_cnt <= '0;
      prev_v    <= 1'b0;
      core_rst  <= 1'b1;
      running   <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      cycle_cnt <= '0;
      instr_cnt <= '0;
      final_pc  <= '0;
    end else if (state == HOLD) begin
      if (hold_cnt == HW'(RST_CYCLES - 1)) begin
        state    <= RUN;
        core_rst <= 1'b0;
        running  <= 1'b1;
      end else hold_cnt <= hold_cnt + 1'b1;
    end else if (state == RUN) begin
      if (instr_valid) begin
        instr_cnt <= &instr_cnt ? instr_cnt : instr_cnt + 1'b1;
        prev_pc   <= pc_in;
        prev_v    <= 1'b1;
        stall_cnt <= repeat_pc ? stall_cnt + 1'b1 : '0;
      end
      // the terminating cycle is not counted, so a watchdog stop reports MAX_CYCLES-1
      if (end_done || wdog_hit) begin
        state    <= end_done ? DONE : TIMEOUT;
        done     <= end_done;
        timeout  <= !end_done;
        final_pc <= pc_in;
        core_rst <= 1'b1;
        running  <= 1'b0;
      end else cycle_cnt <= &cycle_cnt ? cycle_cnt : cycle_cnt + 1'b1;
    end else if (state != IDLE && state != DONE && state != TIMEOUT) state <= IDLE;
  end
`ifdef SIM_RUN_CTRL_TRACE_EN
  logic [PC_WIDTH-1:0] tbuf [TRACE_DEPTH];
  logic [AW-1:0]       wptr;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst || go) begin
      wptr <= '0;
      for (int i = 0; i < TRACE_DEPTH; i++) tbuf[i] <= '0;
    end else if (state == RUN && instr_valid) begin
      tbuf[wptr] <= pc_in;
      wptr       <= wptr + 1'b1;
    end
  end
  assign trace_data = tbuf[wptr - 1'b1 - trace_addr];
`else
  logic unused_trace;
  assign unused_trace = ^trace_addr;
  assign trace_data   = '0;
`endif
endmodule

// File: tb/tb_sim_run_ctrl.sv
// tb_sim_run_ctrl: table-driven and directed checks of sim_run_ctrl sequencing and completion.
module tb_sim_run_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] pc_in = '0;
  logic        instr_valid = 1'b0;
  logic        halt_req = 1'b0;
  logic        core_rst, running, done, timeout;
  logic [31:0] cycle_cnt, instr_cnt, final_pc, trace_data;
  logic [3:0]  trace_addr = '0;
  int checks = 0;
  int failures = 0;
  sim_run_ctrl #(.MAX_CYCLES(50)) dut (
    .clk(clk), .rst(rst), .start(start), .pc_in(pc_in), .instr_valid(instr_valid),
    .halt_req(halt_req), .core_rst(core_rst), .running(running), .done(done),
    .timeout(timeout), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt), .final_pc(final_pc),
    .trace_addr(trace_addr), .trace_data(trace_data)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic        st, iv, h;
    logic [31:0] pc;
    logic        crst, run, dn, to;
    logic [31:0] cyc, icnt, fp;
  } vec_t;
  vec_t tbl [15];
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask
  task automatic status(input string tag, input logic crst, input logic run, input logic dn, input logic to);
    chk({tag, ".core_rst"}, 32'(core_rst), 32'(crst));
    chk({tag, ".running"}, 32'(running), 32'(run));
    chk({tag, ".done"}, 32'(done), 32'(dn));
    chk({tag, ".timeout"}, 32'(timeout), 32'(to));
  endtask
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic ret(input logic [31:0] pc, input logic iv, input logic h);
    pc_in = pc; instr_valid = iv; halt_req = h;
    tick();
    instr_valid = 1'b0; halt_req = 1'b0;
  endtask
  task automatic run_start;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "simulation time limit");
  end
  initial begin
    tbl[0] = '{1, 0, 0, 32'h0,  1, 0, 0, 0, 0, 0, 0};
    tbl[1] = '{0, 0, 0, 32'h0,  1, 0, 0, 0, 0, 0, 0};
    tbl[2] = '{0, 0, 0, 32'h0,  0, 1, 0, 0, 0, 0, 0};
    for (int k = 0; k < 10; k++)
      tbl[3+k] = '{k == 2, 1, 0, 32'(4*k), 0, 1, 0, 0, 32'(k+1), 32'(k+1), 0};
    tbl[13] = '{0, 0, 1, 32'h28, 1, 0, 1, 0, 10, 10, 32'h28};
    tbl[14] = '{0, 1, 1, 32'h99, 1, 0, 1, 0, 10, 10, 32'h28};
    repeat (3) @(negedge clk);
    status("reset", 1, 0, 0, 0);
    chk("reset.cycle_cnt", cycle_cnt, 0);
    chk("reset.instr_cnt", instr_cnt, 0);
    chk("reset.final_pc", final_pc, 0);
    chk("reset.trace_data", trace_data, 0);
    rst = 1'b1;
    tick();
    for (int v = 0; v < 15; v++) begin
      start = tbl[v].st; instr_valid = tbl[v].iv; halt_req = tbl[v].h; pc_in = tbl[v].pc;
      tick();
      status($sformatf("vec%0d", v), tbl[v].crst, tbl[v].run, tbl[v].dn, tbl[v].to);
      chk($sformatf("vec%0d.cycle_cnt", v), cycle_cnt, tbl[v].cyc);
      chk($sformatf("vec%0d.instr_cnt", v), instr_cnt, tbl[v].icnt);
      chk($sformatf("vec%0d.final_pc", v), final_pc, tbl[v].fp);
    end
    start = 1'b0; instr_valid = 1'b0; halt_req = 1'b0;
    run_start();
    status("stall.start", 0, 1, 0, 0);
    chk("stall.cycle_cnt0", cycle_cnt, 0);
    ret(32'h0, 1, 0); ret(32'h4, 1, 0); ret(32'h8, 1, 0);
    ret(32'h8, 1, 0); ret(32'h8, 1, 0); ret(32'h8, 1, 0);
    status("stall.third_repeat", 0, 1, 0, 0);
    ret(32'h8, 1, 0);
    status("stall.fourth_repeat", 1, 0, 1, 0);
    chk("stall.final_pc", final_pc, 32'h8);
    run_start();
    for (int i = 0; i < 49; i++) ret(32'h100 + 32'(4*i), 1, 0);
    status("wdog.before", 0, 1, 0, 0);
    chk("wdog.cycle_before", cycle_cnt, 49);
    ret(32'h200, 1, 0);
    status("wdog.hit", 1, 0, 0, 1);
    chk("wdog.cycle_cnt", cycle_cnt, 49);
    chk("wdog.instr_cnt", instr_cnt, 50);
    chk("wdog.final_pc", final_pc, 32'h200);
    tick();
    status("wdog.sticky", 1, 0, 0, 1);
    run_start();
    status("wdog2.start", 0, 1, 0, 0);
    for (int i = 0; i < 49; i++) ret(32'h100 + 32'(4*i), 1, 0);
    ret(32'h204, 1, 1);
    status("wdog2.halt_wins", 1, 0, 1, 0);
    chk("wdog2.final_pc", final_pc, 32'h204);
    run_start();
    for (int i = 0; i < 20; i++) ret(32'(4*i), 1, 0);
    ret(32'h50, 0, 1);
    status("trace.done", 1, 0, 1, 0);
    trace_addr = 4'd0;
    #1;
`ifdef SIM_RUN_CTRL_TRACE_EN
    chk("trace.addr0", trace_data, 32'h4C);
    trace_addr = 4'd15;
    #1;
    chk("trace.addr15", trace_data, 32'h10);
`else
    chk("trace.addr0", trace_data, 32'h0);
    trace_addr = 4'd15;
    #1;
    chk("trace.addr15", trace_data, 32'h0);
`endif
    trace_addr = 4'd0;
    @(negedge clk);
    run_start();
    chk("trace.cleared_on_start", trace_data, 32'h0);
    for (int i = 0; i < 20; i++) ret(32'h300 + 32'(4*i), 1, 0);
    chk("midrst.cycle_before", cycle_cnt, 20);
    #2 rst = 1'b0;
    #1;
    status("midrst", 1, 0, 0, 0);
    chk("midrst.cycle_cnt", cycle_cnt, 0);
    chk("midrst.instr_cnt", instr_cnt, 0);
    chk("midrst.final_pc", final_pc, 0);
    chk("midrst.trace_data", trace_data, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    status("midrst.idle", 1, 0, 0, 0);
    run_start();
    status("restart", 0, 1, 0, 0);
    chk("restart.cycle_cnt", cycle_cnt, 0);
    ret(32'h400, 1, 0);
    chk("restart.cycle_cnt1", cycle_cnt, 1);
    chk("restart.instr_cnt1", instr_cnt, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
